dtc_score_collector: RTL and testbench
======================================

// Module: dtc_score_collector
// PURPOSE
//  Consumes the W-bit class codes produced by the dtc_* decision-tree classifiers, paired with a golden label.
//  Over one frame (start .. last sample) it accumulates sample count, exact-match count and per-bit error total.
//  It then presents one result record through a valid/ready handshake.
//  Sits between the classifier outputs and the scoreboard/CSR readout.
// PARAMETERS
//  W      7   width of prediction and label codes
//  CNT_W  16  width of the sample and match counters
//  BE_W   CNT_W+$clog2(W+1)   width of the bit-error accumulator (derived, localparam)
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  rst_n       in   1      synchronous reset, active low
//  start       in   1      1-cycle pulse: clear accumulators, open a frame
//  in_valid    in   1      sample valid
//  in_ready    out  1      sample accepted when in_valid & in_ready
//  in_pred     in   W      classifier output code
//  in_label    in   W      golden code
//  in_last     in   1      qualifies the final sample of the frame
//  res_valid   out  1      result record valid
//  res_ready   in   1      result consumed when res_valid & res_ready
//  res_total   out  CNT_W  samples accepted in frame
//  res_match   out  CNT_W  samples with in_pred == in_label
//  res_biterr  out  BE_W   sum of popcount(in_pred ^ in_label)
//  res_sat     out  1      any accumulator saturated during frame
//  busy        out  1      high in RUN or DRAIN
// BEHAVIOUR
//  Reset: state IDLE; all accumulators 0; in_ready=0, res_valid=0, res_sat=0, busy=0; stage-1 register invalid.
//    Applies on any clk edge with rst_n=0, including mid-frame; a partial frame is discarded, no record emitted.
//  FSM IDLE -> RUN -> DRAIN -> REPORT -> IDLE:
//   IDLE:   in_ready=0. start=1 -> clear accumulators and res_sat, go RUN.
//   RUN:    in_ready=1 (combinational from state only, not from in_valid).
//           Handshake with in_last=1 -> DRAIN.
//           start=1 in RUN -> restart: clear accumulators, drop any sample offered that cycle, stay RUN.
//   DRAIN:  in_ready=0, one cycle, lets the last sample's stage-1 result enter the accumulators. -> REPORT.
//   REPORT: res_valid=1. res_* stable until res_valid & res_ready, then go IDLE.
//           Handshake in same cycle res_valid rises is legal. start ignored in DRAIN and REPORT.
//  Pipeline:
//   Stage 1 registers eq = (in_pred==in_label) and pc = popcount(in_pred^in_label) on each accepted sample.
//   Stage 2 adds the stage-1 values into the accumulators the next cycle.
//   Latency: handshake at cycle t is reflected in res_* counters at t+2.
//   Back-to-back samples every cycle are supported (throughput 1/clk).
//  Arithmetic: every accumulator is unsigned and saturates at all-ones; it never wraps.
//   Any saturation sets res_sat, which is sticky until the next start or reset.
//   pc range is 0..W.
//  Frame with in_last on the first sample: total=1, valid result.
//  X on in_pred/in_label while in_valid=0 must not affect state.
//  res_* outputs hold the last frame's values in IDLE until the next start clears them.
// TESTING
//  1 Reset values: rst_n low 3 cycles -> in_ready=0, res_valid=0, busy=0, all res_* = 0.
//  2 Basic frame: start; 4 samples (pred,label) = (7'h05,7'h05), (7'h7F,7'h00), (7'h11,7'h10), (7'h2A,7'h2A) with last on the 4th.
//    -> res_total=4, res_match=2, res_biterr=8, res_sat=0.
//    res_valid rises 2 cycles after the last handshake.
//  3 Backpressure:
//    a) hold res_ready=0 20 cycles -> res_* stable, in_ready=0, start pulses ignored.
//    b) assert res_ready -> IDLE next cycle.
//  4 Restart and throttling:
//    a) start mid-frame after 3 samples, then 2 matching samples + last -> total=2, match=2, biterr=0.
//    b) random in_valid gaps -> same totals as gapless run.
//  5 Saturation: CNT_W=4, 20 matching samples -> total=15, match=15, res_sat=1.
//    A following frame after start -> res_sat=0.
//  6 Reset mid-frame: rst_n low for 1 cycle after 2 samples -> IDLE, no res_valid.
//    The next full frame counts from 0.

Source files
------------

// File: rtl/dtc_score_collector.sv
// Frame scoreboard for dtc_* classifier outputs: counts samples, exact matches and bit errors
// over one frame, then offers a single result record on a valid/ready port.
module dtc_score_collector #(
    parameter  int W     = 7,
    parameter  int CNT_W = 16,
    localparam int PC_W  = $clog2(W + 1),
    localparam int BE_W  = CNT_W + PC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_pred,
    input  logic [W-1:0]     in_label,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_total,
    output logic [CNT_W-1:0] res_match,
    output logic [BE_W-1:0]  res_biterr,
    output logic             res_sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_s1_valid;
    logic             r_s1_eq;
    logic [PC_W-1:0]  r_s1_pc;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_match;
    logic [BE_W-1:0]  r_biterr;
    logic             r_sat;

    logic             w_accept;
    logic             w_clear;
    logic [CNT_W:0]   w_total_sum;
    logic [CNT_W:0]   w_match_sum;
    logic [BE_W:0]    w_be_sum;

    function automatic logic [PC_W-1:0] popcount(input logic [W-1:0] v);
        logic [PC_W-1:0] c;
        c = {PC_W{1'b0}};
        for (int i = 0; i < W; i++) begin
            c = c + {{(PC_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // A start in RUN restarts the frame, so the sample offered alongside it is dropped.
    assign w_accept = in_valid & (r_state == S_RUN) & ~start;
    assign w_clear  = start & ((r_state == S_IDLE) | (r_state == S_RUN));

    assign w_total_sum = {1'b0, r_total} + {{CNT_W{1'b0}}, 1'b1};
    assign w_match_sum = {1'b0, r_match} + {{CNT_W{1'b0}}, r_s1_eq};
    assign w_be_sum    = {1'b0, r_biterr} + {{(BE_W+1-PC_W){1'b0}}, r_s1_pc};

    assign in_ready   = (r_state == S_RUN);
    assign res_valid  = (r_state == S_REPORT);
    assign busy       = (r_state == S_RUN) | (r_state == S_DRAIN);
    assign res_total  = r_total;
    assign res_match  = r_match;
    assign res_biterr = r_biterr;
    assign res_sat    = r_sat;

    // Frame sequencing: next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
                else       w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (start)                    w_state_nxt = S_RUN;
                else if (w_accept && in_last) w_state_nxt = S_DRAIN;
                else                          w_state_nxt = S_RUN;
            end
            S_DRAIN: begin
                w_state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (res_ready) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_REPORT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Stage 1: per-sample compare; data loads only on accept so idle X inputs stay out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_eq    <= 1'b0;
            r_s1_pc    <= {PC_W{1'b0}};
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_eq <= (in_pred == in_label);
                r_s1_pc <= popcount(in_pred ^ in_label);
            end
        end
    end

    // Stage 2: saturating accumulators with sticky saturation flag.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_total  <= {CNT_W{1'b0}};
            r_match  <= {CNT_W{1'b0}};
            r_biterr <= {BE_W{1'b0}};
            r_sat    <= 1'b0;
        end else if (r_s1_valid) begin
            r_total  <= w_total_sum[CNT_W] ? {CNT_W{1'b1}} : w_total_sum[CNT_W-1:0];
            r_match  <= w_match_sum[CNT_W] ? {CNT_W{1'b1}} : w_match_sum[CNT_W-1:0];
            r_biterr <= w_be_sum[BE_W]     ? {BE_W{1'b1}}  : w_be_sum[BE_W-1:0];
            r_sat    <= r_sat | w_total_sum[CNT_W] | w_match_sum[CNT_W] | w_be_sum[BE_W];
        end
    end

endmodule

// File: tb/tb_dtc_score_collector.sv
// Directed bench for dtc_score_collector: a default instance plus a CNT_W=4 instance
// sharing the same stimulus, used for the saturation scenario.
module tb_dtc_score_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [6:0]  in_pred;
    logic [6:0]  in_label;
    logic        in_last;
    logic        res_ready;

    logic        in_ready, res_valid, res_sat, busy;
    logic [15:0] res_total, res_match;
    logic [18:0] res_biterr;

    logic        s_in_ready, s_res_valid, s_res_sat, s_busy;
    logic [3:0]  s_res_total, s_res_match;
    logic [6:0]  s_res_biterr;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [6:0] vp [4];
    logic [6:0] vl [4];

    always #5 clk = ~clk;

    dtc_score_collector u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_pred(in_pred),
        .in_label(in_label), .in_last(in_last),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_total(res_total), .res_match(res_match),
        .res_biterr(res_biterr), .res_sat(res_sat), .busy(busy)
    );

    dtc_score_collector #(.W(7), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_pred(in_pred),
        .in_label(in_label), .in_last(in_last),
        .res_valid(s_res_valid), .res_ready(res_ready),
        .res_total(s_res_total), .res_match(s_res_match),
        .res_biterr(s_res_biterr), .res_sat(s_res_sat), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] p, input logic [6:0] l, input logic last);
        in_valid = 1'b1;
        in_pred  = p;
        in_label = l;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_pred  = 7'bx;
        in_label = 7'bx;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_report(input string tag);
        int n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(res_valid), 32'd1);
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vp[0] = 7'h05; vl[0] = 7'h05;
        vp[1] = 7'h7F; vl[1] = 7'h00;
        vp[2] = 7'h11; vl[2] = 7'h10;
        vp[3] = 7'h2A; vl[3] = 7'h2A;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_pred = 7'h00; in_label = 7'h00; res_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_total", 32'(res_total), 32'd0);
        check("rst_match", 32'(res_match), 32'd0);
        check("rst_biterr", 32'(res_biterr), 32'd0);
        check("rst_sat", 32'(res_sat), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame with exact result latency
        pulse_start();
        check("t2_in_ready", 32'(in_ready), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) send(vp[k], vl[k], k == 3);
        check("t2_drain_valid", 32'(res_valid), 32'd0);
        check("t2_drain_ready", 32'(in_ready), 32'd0);
        tick();
        check("t2_valid", 32'(res_valid), 32'd1);
        check("t2_total", 32'(res_total), 32'd4);
        check("t2_match", 32'(res_match), 32'd2);
        check("t2_biterr", 32'(res_biterr), 32'd8);
        check("t2_sat", 32'(res_sat), 32'd0);

        // Backpressure: record held, start ignored
        for (int i = 0; i < 20; i++) begin
            start = (i % 5 == 0);
            tick();
            start = 1'b0;
            check("t3_valid", 32'(res_valid), 32'd1);
            check("t3_total", 32'(res_total), 32'd4);
            check("t3_in_ready", 32'(in_ready), 32'd0);
        end
        check("t3_biterr", 32'(res_biterr), 32'd8);
        accept_result();
        check("t3_idle_valid", 32'(res_valid), 32'd0);
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_hold_total", 32'(res_total), 32'd4);
        check("t3_hold_match", 32'(res_match), 32'd2);

        // Restart mid-frame drops the earlier samples and the one offered with start
        pulse_start();
        check("t4a_cleared", 32'(res_total), 32'd0);
        for (int k = 0; k < 3; k++) send(7'h7F, 7'h00, 1'b0);
        in_valid = 1'b1; in_pred = 7'h7F; in_label = 7'h00; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        send(7'h33, 7'h33, 1'b0);
        send(7'h44, 7'h44, 1'b1);
        wait_report("t4a_valid");
        check("t4a_total", 32'(res_total), 32'd2);
        check("t4a_match", 32'(res_match), 32'd2);
        check("t4a_biterr", 32'(res_biterr), 32'd0);
        accept_result();

        // Throttled input with X on idle data
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(vp[k], vl[k], k == 3);
        end
        wait_report("t4b_valid");
        check("t4b_total", 32'(res_total), 32'd4);
        check("t4b_match", 32'(res_match), 32'd2);
        check("t4b_biterr", 32'(res_biterr), 32'd8);
        check("t4b_sat", 32'(res_sat), 32'd0);
        accept_result();

        // Saturation on the narrow instance
        pulse_start();
        for (int i = 0; i < 20; i++) send(7'(i), 7'(i), i == 19);
        wait_report("t5_valid");
        check("t5_sat_valid", 32'(s_res_valid), 32'd1);
        check("t5_sat_total", 32'(s_res_total), 32'd15);
        check("t5_sat_match", 32'(s_res_match), 32'd15);
        check("t5_sat_biterr", 32'(s_res_biterr), 32'd0);
        check("t5_sat_flag", 32'(s_res_sat), 32'd1);
        check("t5_wide_total", 32'(res_total), 32'd20);
        check("t5_wide_sat", 32'(res_sat), 32'd0);
        accept_result();
        pulse_start();
        check("t5_sat_cleared", 32'(s_res_sat), 32'd0);
        check("t5_total_cleared", 32'(s_res_total), 32'd0);
        send(7'h01, 7'h02, 1'b1);
        wait_report("t5b_valid");
        check("t5b_total", 32'(s_res_total), 32'd1);
        check("t5b_match", 32'(s_res_match), 32'd0);
        check("t5b_biterr", 32'(s_res_biterr), 32'd2);
        check("t5b_sat", 32'(s_res_sat), 32'd0);
        accept_result();

        // Reset mid-frame
        pulse_start();
        send(vp[1], vl[1], 1'b0);
        send(vp[2], vl[2], 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_total", 32'(res_total), 32'd0);
        check("t6_biterr", 32'(res_biterr), 32'd0);
        repeat (3) begin
            tick();
            check("t6_no_valid", 32'(res_valid), 32'd0);
        end
        pulse_start();
        for (int k = 0; k < 4; k++) send(vp[k], vl[k], k == 3);
        wait_report("t6b_valid");
        check("t6b_total", 32'(res_total), 32'd4);
        check("t6b_match", 32'(res_match), 32'd2);
        check("t6b_biterr", 32'(res_biterr), 32'd8);
        accept_result();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
